// File: rtl/dmem_axil_slave.sv
// AXI4-Lite data-memory responder: word RAM with byte strobes, independent AW/W capture, read-first collisions.
// Optional `DMEM_RANGE_CHECK_EN: out-of-range accesses return SLVERR (no write, rdata=0); otherwise addresses wrap.
module dmem_axil_slave #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter string       INIT_FILE   = ""
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] s_axil_awaddr_i,
  input  logic              s_axil_awvalid_i,
  output logic              s_axil_awready_o,
  input  logic [31:0]       s_axil_wdata_i,
  input  logic [3:0]        s_axil_wstrb_i,
  input  logic              s_axil_wvalid_i,
  output logic              s_axil_wready_o,
  output logic [1:0]        s_axil_bresp_o,
  output logic              s_axil_bvalid_o,
  input  logic              s_axil_bready_i,
  input  logic [ADDR_W-1:0] s_axil_araddr_i,
  input  logic              s_axil_arvalid_i,
  output logic              s_axil_arready_o,
  output logic [31:0]       s_axil_rdata_o,
  output logic [1:0]        s_axil_rresp_o,
  output logic              s_axil_rvalid_o,
  input  logic              s_axil_rready_i
);
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic {R_IDLE, R_RESP} r_state_e;

  logic [31:0]       mem_q [DEPTH_WORDS];
  logic              aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  r_state_e          r_state_q, r_state_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  logic             aw_hs, w_hs, commit, w_oor, r_oor;
  logic [IDX_W-1:0] w_idx, r_idx;
  logic             unused_addr_bits;

  assign aw_hs  = s_axil_awvalid_i && !aw_full_q;
  assign w_hs   = s_axil_wvalid_i && !w_full_q;
  // A pending B response stalls the next commit so bresp never changes under the master.
  assign commit = aw_full_q && w_full_q && !bvalid_q;
  assign w_idx  = awaddr_q[IDX_W+1:2];
  assign r_idx  = s_axil_araddr_i[IDX_W+1:2];

`ifdef DMEM_RANGE_CHECK_EN
  assign w_oor = |awaddr_q[ADDR_W-1:IDX_W+2];
  assign r_oor = |s_axil_araddr_i[ADDR_W-1:IDX_W+2];
`else
  assign w_oor = 1'b0;
  assign r_oor = 1'b0;
`endif

  assign unused_addr_bits = ^{awaddr_q[1:0], awaddr_q[ADDR_W-1:IDX_W+2],
                              s_axil_araddr_i[1:0], s_axil_araddr_i[ADDR_W-1:IDX_W+2]};

  always_comb begin
    aw_full_d = aw_full_q;
    awaddr_d  = awaddr_q;
    w_full_d  = w_full_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (aw_hs) begin
      aw_full_d = 1'b1;
      awaddr_d  = s_axil_awaddr_i;
    end else if (commit) begin
      aw_full_d = 1'b0;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      wdata_d  = s_axil_wdata_i;
      wstrb_d  = s_axil_wstrb_i;
    end else if (commit) begin
      w_full_d = 1'b0;
    end
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = w_oor ? 2'b10 : 2'b00;
    end else if (bvalid_q && s_axil_bready_i) begin
      bvalid_d = 1'b0;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (s_axil_arvalid_i) begin
          rdata_d   = r_oor ? 32'h0 : mem_q[r_idx];
          rresp_d   = r_oor ? 2'b10 : 2'b00;
          r_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (s_axil_rready_i) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_full_q <= 1'b0;
      awaddr_q  <= '0;
      w_full_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      aw_full_q <= aw_full_d;
      awaddr_q  <= awaddr_d;
      w_full_q  <= w_full_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // RAM is not reset; the read port samples before this write lands (read-first).
  always_ff @(posedge clk_i) begin
    if (commit && !w_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem_q[w_idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign s_axil_awready_o = !aw_full_q;
  assign s_axil_wready_o  = !w_full_q;
  assign s_axil_bvalid_o  = bvalid_q;
  assign s_axil_bresp_o   = bresp_q;
  assign s_axil_arready_o = (r_state_q == R_IDLE);
  assign s_axil_rvalid_o  = (r_state_q == R_RESP);
  assign s_axil_rdata_o   = rdata_q;
  assign s_axil_rresp_o   = rresp_q;
endmodule
